wait_cycles_arbiter: RTL
========================

Name: wait_cycles_arbiter

Overview:
Round-robin arbiter that shares one wait_cycles delay engine among N_REQ requesters. Each requester presents a cycle count and holds valid until it gets a one-cycle ready pulse. The arbiter serialises requests: it forwards one count at a time to the engine, waits for the engine's completion pulse, then returns the pulse to the requester that owns the request. It sits between generated thread logic and a single wait_cycles instance on the same clk/rst.

Parameters:
N_REQ, 4, number of requesters (2..16)
WIDTH, 32, cycle-count width; must match engine req_0 width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  N_REQ  per-requester request; held high until matching req_ready pulse
req_0  in  N_REQ*WIDTH  per-requester cycle count; requester i uses bits [i*WIDTH +: WIDTH]
req_ready  out  N_REQ  per-requester completion pulse, registered
eng_req_valid  out  1  request pulse to engine, registered
eng_req_0  out  WIDTH  count to engine, registered
eng_req_ready  in  1  engine completion pulse
busy  out  1  high whenever state != IDLE
grant_idx  out  clog2(N_REQ)  index of the requester currently being served

Behaviour:
- Reset values: req_ready=0, eng_req_valid=0, eng_req_0=0, busy=0, grant_idx=0, state=IDLE, rr_last=N_REQ-1. Requester 0 therefore has top priority after reset.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req_valid bit is high, pick the winner. Search order is rr_last+1, rr_last+2, ... modulo N_REQ; the first set bit wins. Latch grant_idx=winner and eng_req_0=req_0[winner]. Set eng_req_valid=1. Go to ISSUE. If no bit is set, stay in IDLE.
- ISSUE: eng_req_valid is high for exactly this one cycle. Clear it on exit. Go to WAIT.
- WAIT: while eng_req_ready=0, stay. When eng_req_ready=1, set req_ready[grant_idx]=1 and go to DONE.
- DONE: req_ready[grant_idx] is high for exactly this one cycle. Clear it on exit. Set rr_last=grant_idx. Go to IDLE.
- Latency:
  - Valid sampled in IDLE at cycle t: eng_req_valid is high in t+1.
  - Engine ready in cycle d: req_ready[i] is high in d+1, IDLE is re-entered in d+2.
  - Minimum arbiter overhead is 3 cycles beyond engine time.
- The count is captured in IDLE only. Changes to req_0 after the grant are ignored.
- eng_req_valid is never held for more than one cycle. This prevents the engine from restarting on a stale valid after it completes.
- eng_req_ready outside WAIT is ignored: no state change, no req_ready.
- A requester that drops req_valid after the grant still receives its req_ready pulse; the request is not cancelled.
- A requester that drops req_valid before the grant is never served.
- At most one req_ready bit is high in any cycle. req_ready is only ever asserted for grant_idx.
- A requester re-asserting valid right after its pulse competes normally. Round-robin puts it last among active requesters.
- Count 0 is forwarded unchanged; the engine's minimal completion applies.
- rst mid-operation: all outputs and state return to reset values on the next edge. Any pending grant is dropped with no req_ready. The engine shares rst, so it is also reset.
- Simultaneous requests: every active requester is served exactly once before any requester is served twice.

Test Plan:
- Single request: after reset, req_valid[2]=1 with req_0=5 -> eng_req_valid pulses one cycle with eng_req_0=5, grant_idx=2, busy=1. Engine ready arrives. One cycle later req_ready[2]=1 for exactly one cycle, and no other ready bit rises.
- All 4 requesters assert together with counts 3,7,1,4 -> service order 0,1,2,3. Each req_ready pulse follows its own engine completion. Engine requests never overlap.
- Fairness: requesters 1 and 3 hold valid continuously and re-assert after every pulse -> grants strictly alternate 1,3,1,3 over 8 grants.
- Late change and drop: requester 0 changes req_0 from 10 to 2 one cycle after grant, then drops valid -> engine receives 10, req_ready[0] still pulses once.
- Spurious engine ready: pulse eng_req_ready while in IDLE and in ISSUE -> no req_ready, no state change.
- Reset mid-WAIT: assert rst while serving requester 1 -> next cycle busy=0, all ready=0, rr_last=N_REQ-1. With requesters 0 and 1 valid afterwards, requester 0 is granted first.

Source files
------------

// File: rtl/wait_cycles_arbiter.sv
// Round-robin arbiter sharing one wait_cycles engine among N_REQ requesters.
// Engine request one cycle after grant, requester pulse one cycle after engine completion.
module wait_cycles_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WIDTH-1:0]     req_0,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       eng_req_valid,
    output logic [WIDTH-1:0]           eng_req_0,
    input  logic                       eng_req_ready,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_idx
);

    localparam int GW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state, state_nxt;
    logic [GW-1:0]      rr_last, rr_last_nxt;
    logic [GW-1:0]      grant_nxt;
    logic [GW-1:0]      winner;
    logic               found;
    int                 idx;
    logic [WIDTH-1:0]   eng_req_0_nxt;
    logic               eng_req_valid_nxt;
    logic [N_REQ-1:0]   req_ready_nxt;

    // Search starts just after the last served requester, so it ends up last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(rr_last) + k) % N_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = GW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt         = state;
        rr_last_nxt       = rr_last;
        grant_nxt         = grant_idx;
        eng_req_0_nxt     = eng_req_0;
        eng_req_valid_nxt = 1'b0;
        req_ready_nxt     = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt         = winner;
                    eng_req_0_nxt     = req_0[int'(winner)*WIDTH +: WIDTH];
                    eng_req_valid_nxt = 1'b1;
                    state_nxt         = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (eng_req_ready) begin
                    req_ready_nxt[grant_idx] = 1'b1;
                    state_nxt                = DONE;
                end
            end
            DONE: begin
                rr_last_nxt = grant_idx;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rr_last       <= GW'(N_REQ - 1);
            grant_idx     <= '0;
            eng_req_0     <= '0;
            eng_req_valid <= 1'b0;
            req_ready     <= '0;
        end else begin
            state         <= state_nxt;
            rr_last       <= rr_last_nxt;
            grant_idx     <= grant_nxt;
            eng_req_0     <= eng_req_0_nxt;
            eng_req_valid <= eng_req_valid_nxt;
            req_ready     <= req_ready_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule
